// File: rtl/psum_accumulator.sv
// Consumer-side partner of the 4-lane MAC PE: issues beats, tracks them through the PE pipeline,
// accumulates p_sum over a group count and presents a requantized int8 result on a valid/ready port.
module psum_accumulator #(
    parameter int unsigned PE_LAT = 3,
    parameter int unsigned G_W    = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned SHIFT  = 8,
    parameter bit          RELU   = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [G_W-1:0]   i_num_groups,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [24:0]      i_p_sum,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_out_acc,
    output logic [7:0]       o_out_q,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

    localparam logic signed [ACC_W-1:0] QMax = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] QMin = ACC_W'(-128);

    state_e            r_state, w_state_d;
    logic [G_W-1:0]    r_groups, r_issued, r_rcvd;
    logic [PE_LAT-1:0] r_tag, w_tag_d;
    logic [ACC_W-1:0]  r_acc, r_out_acc, w_psum_ext, w_sum;
    logic [7:0]        r_out_q, w_q;
    logic              r_done;
    logic              w_issue, w_tag_out, w_last;
    logic signed [ACC_W-1:0] w_shifted;

    assign w_tag_out  = r_tag[PE_LAT-1];
    assign w_last     = (r_rcvd == r_groups - G_W'(1));
    assign w_psum_ext = {{(ACC_W-25){i_p_sum[24]}}, i_p_sum};
    assign w_sum      = r_acc + w_psum_ext;

    assign o_out_acc = r_out_acc;
    assign o_out_q   = r_out_q;
    assign o_busy    = (r_state != StIdle);
    assign o_done    = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        w_issue     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) w_state_d = StAccum;
            end
            StAccum: begin
                o_in_ready = (r_issued < r_groups);
                w_issue    = i_in_valid && o_in_ready;
                if (w_tag_out && w_last) w_state_d = StOut;
            end
            StOut: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Tag delay line mirrors the PE pipeline so each result is matched to its issue edge.
    always_comb begin
        w_tag_d    = r_tag << 1;
        w_tag_d[0] = w_issue;
    end

    always_comb begin
        w_shifted = $signed(w_sum) >>> SHIFT;
        if (RELU && (w_shifted < 0)) w_shifted = '0;
        if (w_shifted > QMax) begin
            w_q = 8'h7f;
        end else if (w_shifted < QMin) begin
            w_q = 8'h80;
        end else begin
            w_q = w_shifted[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_groups  <= '0;
            r_issued  <= '0;
            r_rcvd    <= '0;
            r_tag     <= '0;
            r_acc     <= '0;
            r_out_acc <= '0;
            r_out_q   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_tag  <= w_tag_d;
            r_done <= (r_state == StOut) && i_out_ready;
            if (r_state == StIdle && i_start) begin
                r_groups <= (i_num_groups == '0) ? G_W'(1) : i_num_groups;
                r_acc    <= '0;
                r_issued <= '0;
                r_rcvd   <= '0;
            end
            if (w_issue) r_issued <= r_issued + G_W'(1);
            if (r_state == StAccum && w_tag_out) begin
                r_acc  <= w_sum;
                r_rcvd <= r_rcvd + G_W'(1);
                if (w_last) begin
                    r_out_acc <= w_sum;
                    r_out_q   <= w_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: two instances (ReLU on/off, SHIFT=2) share stimulus; a PE model
// returns each accepted beat's value three cycles later and drives junk on p_sum otherwise.
module tb_psum_accumulator;
    localparam int Shift = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  num_groups = '0;
    logic [24:0] p_sum;
    logic        in_ready, out_valid, busy, done;
    logic [31:0] out_acc;
    logic [7:0]  out_q;
    logic        in_ready_l, out_valid_l, busy_l, done_l;
    logic [31:0] out_acc_l;
    logic [7:0]  out_q_l;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic        pe_v[3];
    logic [24:0] pe_d[3];
    logic [24:0] garbage;
    logic        pe_in_v = 1'b0;
    logic [24:0] pe_in_d = '0;

    logic [24:0] job_vals[$];
    bit          job_pat[$];

    psum_accumulator #(.PE_LAT(3), .G_W(8), .ACC_W(32), .SHIFT(Shift), .RELU(1'b1)) u_dut_relu (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_groups(num_groups),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_p_sum(p_sum),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_acc(out_acc),
        .o_out_q(out_q), .o_busy(busy), .o_done(done)
    );

    psum_accumulator #(.PE_LAT(3), .G_W(8), .ACC_W(32), .SHIFT(Shift), .RELU(1'b0)) u_dut_lin (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_groups(num_groups),
        .i_in_valid(in_valid), .o_in_ready(in_ready_l), .i_p_sum(p_sum),
        .o_out_valid(out_valid_l), .i_out_ready(out_ready), .o_out_acc(out_acc_l),
        .o_out_q(out_q_l), .o_busy(busy_l), .o_done(done_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pe_v[i] <= 1'b0;
                pe_d[i] <= '0;
            end
        end else begin
            pe_v[0] <= pe_in_v;
            pe_d[0] <= pe_in_d;
            pe_v[1] <= pe_v[0];
            pe_d[1] <= pe_d[0];
            pe_v[2] <= pe_v[1];
            pe_d[2] <= pe_d[1];
        end
    end

    always @(posedge clk) garbage <= 25'($urandom);
    assign p_sum = pe_v[2] ? pe_d[2] : garbage;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1);
    end

    function automatic logic [7:0] ref_q(input longint sum, input bit relu);
        longint t;
        longint div;
        div = longint'(1) << Shift;
        t = sum / div;
        if (sum < 0 && (sum % div) != 0) t = t - 1;
        if (relu && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return 8'(t);
    endfunction

    function automatic logic [24:0] rnd_psum();
        return 25'($urandom_range(0, 131072) - 65536);
    endfunction

    task automatic tick(input logic st, input logic v, input logic iss, input logic [24:0] d);
        start = st;
        in_valid = v;
        pe_in_v = iss;
        pe_in_d = d;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
    endtask

    // Drives one job up to the first out_valid; lat is in edges after the start edge, -1 on timeout.
    task automatic run_job(input int ng, output int lat, output longint exp_sum, output int rdy_err);
        int g, issued, s;
        logic v, exp_rdy, iss;
        logic [24:0] d;
        g = (ng == 0) ? 1 : ng;
        issued = 0;
        exp_sum = 0;
        rdy_err = 0;
        lat = -1;
        num_groups = 8'(ng);
        tick(1'b1, 1'b0, 1'b0, '0);
        s = cyc;
        num_groups = 8'($urandom);
        for (int k = 0; k < 400; k++) begin
            v = (k < job_pat.size()) ? job_pat[k] : 1'b1;
            exp_rdy = (issued < g);
            if (in_ready !== exp_rdy || in_ready_l !== exp_rdy) rdy_err++;
            iss = v && exp_rdy;
            d = '0;
            if (iss) begin
                d = job_vals[issued];
                exp_sum += longint'($signed(d));
                issued++;
            end
            tick(1'b0, v, iss, d);
            if (out_valid === 1'b1) begin
                lat = cyc - s;
                break;
            end
        end
        in_valid = 1'b0;
        pe_in_v = 1'b0;
    endtask

    // One accepting edge; returns {done, out_valid, busy, done_l} just after it.
    task automatic handshake(output logic [3:0] obs);
        out_ready = 1'b1;
        tick(1'b0, 1'b0, 1'b0, '0);
        out_ready = 1'b0;
        obs = {done, out_valid, busy, done_l};
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({in_ready, out_valid, busy, done, in_ready_l, out_valid_l, busy_l, done_l} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {in_ready, out_valid, busy, done, in_ready_l, out_valid_l, busy_l, done_l});
        end
        n_vec++;
        if (out_acc !== 32'd0 || out_q !== 8'd0 || out_acc_l !== 32'd0 || out_q_l !== 8'd0) begin
            n_err++;
            $display("FAIL reset_data: got acc=%0h q=%0h want 0 0", out_acc, out_q);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat, re;
        longint es;
        logic [3:0] obs;
        job_pat = {};
        job_vals = {25'd100, 25'd200};
        run_job(2, lat, es, re);
        n_vec++;
        if (lat != 5) begin n_err++; $display("FAIL basic_lat: got %0d want 5", lat); end
        n_vec++;
        if (out_acc !== 32'd300 || out_acc_l !== 32'd300) begin
            n_err++; $display("FAIL basic_acc: got %0d want 300", $signed(out_acc));
        end
        n_vec++;
        if (out_q !== 8'd75 || out_q_l !== 8'd75) begin
            n_err++; $display("FAIL basic_q: got %0d/%0d want 75", out_q, out_q_l);
        end
        n_vec++;
        if (re != 0 || busy !== 1'b1) begin
            n_err++; $display("FAIL basic_ready: got rdy_err=%0d busy=%b want 0 1", re, busy);
        end
        handshake(obs);
        n_vec++;
        if (obs !== 4'b1001) begin n_err++; $display("FAIL basic_hs: got %b want 1001", obs); end
        tick(1'b0, 1'b0, 1'b0, '0);
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_saturation();
        logic [24:0] vals[3] = '{25'd1000, 25'h1fffc18, 25'h1fffc18};
        logic [7:0] exp_r[3] = '{8'd127, 8'd0, 8'd0};
        logic [7:0] exp_l[3] = '{8'd127, 8'h80, 8'h80};
        int lat, re;
        longint es;
        logic [3:0] obs;
        for (int i = 0; i < 3; i++) begin
            job_pat = {};
            job_vals = {vals[i]};
            run_job(1, lat, es, re);
            n_vec++;
            if (lat != 4 || $signed(out_acc) != $signed(vals[i])) begin
                n_err++;
                $display("FAIL sat_acc%0d: got lat=%0d acc=%0d want 4 %0d", i, lat,
                         $signed(out_acc), $signed(vals[i]));
            end
            n_vec++;
            if (out_q !== exp_r[i] || out_q_l !== exp_l[i]) begin
                n_err++;
                $display("FAIL sat_q%0d: got %0h/%0h want %0h/%0h", i, out_q, out_q_l,
                         exp_r[i], exp_l[i]);
            end
            handshake(obs);
        end
    endtask

    task automatic test_gapped();
        int lat, re;
        longint es;
        logic [3:0] obs;
        job_pat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        job_vals = {rnd_psum(), rnd_psum(), rnd_psum()};
        run_job(3, lat, es, re);
        n_vec++;
        if (lat != 9) begin n_err++; $display("FAIL gap_lat: got %0d want 9", lat); end
        n_vec++;
        if (re != 0) begin n_err++; $display("FAIL gap_ready: got %0d errors want 0", re); end
        n_vec++;
        if (longint'($signed(out_acc)) != es) begin
            n_err++; $display("FAIL gap_acc: got %0d want %0d", $signed(out_acc), es);
        end
        handshake(obs);
    endtask

    task automatic test_backpressure();
        int lat, re;
        longint es;
        logic [3:0] obs;
        job_pat = {};
        job_vals = {rnd_psum(), rnd_psum()};
        run_job(2, lat, es, re);
        for (int i = 0; i < 5; i++) begin
            num_groups = 8'($urandom_range(1, 9));
            tick(1'b1, 1'b1, 1'b0, '0);
            n_vec++;
            if (out_valid !== 1'b1 || longint'($signed(out_acc)) != es ||
                out_q !== ref_q(es, 1'b1) || out_q_l !== ref_q(es, 1'b0) || done !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b acc=%0d q=%0h done=%b want 1 %0d %0h 0", i,
                         out_valid, $signed(out_acc), out_q, done, es, ref_q(es, 1'b1));
            end
        end
        in_valid = 1'b0;
        handshake(obs);
        n_vec++;
        if (obs !== 4'b1001) begin n_err++; $display("FAIL bp_hs: got %b want 1001", obs); end
        tick(1'b0, 1'b0, 1'b0, '0);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_after: got done=%b busy=%b rdy=%b want 0 0 0", done, busy, in_ready);
        end
    endtask

    task automatic test_zero_count();
        int lat, re;
        longint es;
        logic [3:0] obs;
        job_pat = {};
        job_vals = {rnd_psum()};
        run_job(0, lat, es, re);
        n_vec++;
        if (lat != 4 || re != 0) begin
            n_err++; $display("FAIL zero_cnt: got lat=%0d rdy_err=%0d want 4 0", lat, re);
        end
        n_vec++;
        if (longint'($signed(out_acc)) != es) begin
            n_err++; $display("FAIL zero_acc: got %0d want %0d", $signed(out_acc), es);
        end
        handshake(obs);
    endtask

    task automatic test_reset_midjob();
        int lat, re;
        longint es;
        logic [3:0] obs;
        // Leave a nonzero result registered so the async clear is observable.
        job_pat = {};
        job_vals = {25'd1234};
        run_job(1, lat, es, re);
        handshake(obs);
        num_groups = 8'd4;
        tick(1'b1, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b1, rnd_psum());
        tick(1'b0, 1'b1, 1'b1, rnd_psum());
        tick(1'b0, 1'b1, 1'b1, rnd_psum());
        in_valid = 1'b0;
        pe_in_v = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, busy, done} !== 4'h0 || out_acc !== 32'd0 || out_q !== 8'd0) begin
            n_err++;
            $display("FAIL midrst_clear: got ctrl=%b acc=%0h q=%0h want 0000 0 0",
                     {in_ready, out_valid, busy, done}, out_acc, out_q);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        job_vals = {25'd40};
        run_job(1, lat, es, re);
        n_vec++;
        if (lat != 4 || out_acc !== 32'd40 || out_q !== 8'd10) begin
            n_err++;
            $display("FAIL midrst_next: got lat=%0d acc=%0d q=%0d want 4 40 10", lat,
                     $signed(out_acc), out_q);
        end
        handshake(obs);
    endtask

    task automatic test_back_to_back();
        int lat, re;
        longint es;
        logic [3:0] obs;
        job_pat = {};
        job_vals = {rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum(), rnd_psum()};
        run_job(5, lat, es, re);
        n_vec++;
        if (lat != 8 || longint'($signed(out_acc)) != es) begin
            n_err++;
            $display("FAIL b2b_first: got lat=%0d acc=%0d want 8 %0d", lat, $signed(out_acc), es);
        end
        handshake(obs);
        job_vals = {rnd_psum(), rnd_psum(), rnd_psum()};
        run_job(3, lat, es, re);
        n_vec++;
        if (lat != 6 || longint'($signed(out_acc)) != es || re != 0) begin
            n_err++;
            $display("FAIL b2b_second: got lat=%0d acc=%0d rdy_err=%0d want 6 %0d 0", lat,
                     $signed(out_acc), re, es);
        end
        handshake(obs);
    endtask

    task automatic test_random();
        int lat, re, g, ones, pos;
        longint es;
        logic [3:0] obs;
        for (int j = 0; j < 8; j++) begin
            g = $urandom_range(1, 8);
            job_pat = {};
            job_vals = {};
            for (int i = 0; i < 3 * g; i++) job_pat.push_back($urandom_range(0, 9) < 7);
            for (int i = 0; i < g; i++) job_vals.push_back(rnd_psum());
            ones = 0;
            pos = 0;
            for (int k = 0; ones < g; k++) begin
                if (k >= job_pat.size() || job_pat[k]) begin
                    ones++;
                    pos = k;
                end
            end
            run_job(g, lat, es, re);
            n_vec++;
            if (lat != pos + 4 || re != 0) begin
                n_err++;
                $display("FAIL rnd%0d_timing: got lat=%0d rdy_err=%0d want %0d 0", j, lat, re,
                         pos + 4);
            end
            n_vec++;
            if (longint'($signed(out_acc)) != es || longint'($signed(out_acc_l)) != es) begin
                n_err++;
                $display("FAIL rnd%0d_acc: got %0d want %0d", j, $signed(out_acc), es);
            end
            n_vec++;
            if (out_q !== ref_q(es, 1'b1) || out_q_l !== ref_q(es, 1'b0)) begin
                n_err++;
                $display("FAIL rnd%0d_q: got %0h/%0h want %0h/%0h", j, out_q, out_q_l,
                         ref_q(es, 1'b1), ref_q(es, 1'b0));
            end
            for (int w = $urandom_range(0, 3); w > 0; w--) tick(1'b0, 1'b0, 1'b0, '0);
            handshake(obs);
            n_vec++;
            if (obs !== 4'b1001) begin n_err++; $display("FAIL rnd%0d_hs: got %b want 1001", j, obs); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gapped();
        test_backpressure();
        test_zero_count();
        test_reset_midjob();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
